karatsuba_seq16: RTL and testbench

- Sequential 16x16 unsigned multiplier controller built around one shared 8x8 `karatsuba` combinational instance (ports X, Y, Z).
- Uses the subtractive Karatsuba form, so every partial product is a true 8x8 operation. It schedules three passes through the shared multiplier, then recombines them into a 32-bit product.
- Valid/ready handshake on input and output; sits between the operand source and any consumer of wide products.

---
 rtl/karatsuba_seq16_pkg.sv | 24 ++
 rtl/karatsuba_seq16_if.sv | 30 +++
 rtl/karatsuba.sv | 12 +
 rtl/karatsuba_seq16.sv | 114 +++++++++++
 tb/tb_karatsuba_seq16.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/karatsuba_seq16_pkg.sv
// kara_pkg: shared widths, FSM state encoding and a small helper for the
// sequential 16x16 Karatsuba multiplier.
package kara_pkg;

    localparam int HALF_W = 8;
    localparam int FULL_W = 16;
    localparam int PROD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        M0,
        M2,
        M1,
        COMB,
        DONE
    } state_t;

    // Magnitude of the difference of two half-width operands.
    function automatic logic [HALF_W-1:0] abs_diff(input logic [HALF_W-1:0] x,
                                                   input logic [HALF_W-1:0] y);
        return (x < y) ? (y - x) : (x - y);
    endfunction

endpackage

// File: rtl/karatsuba_seq16_if.sv
// karatsuba_seq16_if: operand/product handshake bundle.
//   in_valid/in_ready/a/b    : operand side (source -> multiplier)
//   out_valid/out_ready/p    : product side (multiplier -> consumer)
//   op_count                 : delivered-product counter (CNT_W bits)
// master = operand source / product consumer, slave = multiplier.
interface karatsuba_seq16_if #(
    parameter int CNT_W = 16
);
    import kara_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [FULL_W-1:0] a;
    logic [FULL_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] p;
    logic [CNT_W-1:0]  op_count;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, op_count
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, op_count
    );

endinterface

// File: rtl/karatsuba.sv
// karatsuba: 8x8 unsigned combinational multiplier.
//   X, Y : 8-bit operands
//   Z    : 16-bit product X*Y
module karatsuba (
    input  logic [7:0]  X,
    input  logic [7:0]  Y,
    output logic [15:0] Z
);

    assign Z = {8'b0, X} * {8'b0, Y};

endmodule

// File: rtl/karatsuba_seq16.sv
// karatsuba_seq16: sequential 16x16 unsigned multiplier that schedules the
// three subtractive-Karatsuba partial products through one shared 8x8
// multiplier and recombines them into a 32-bit product.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : operand/product handshake (slave side); bus CNT_W must match CNT_W
module karatsuba_seq16
    import kara_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    karatsuba_seq16_if.slave    bus
);

    state_t state_q, state_d;

    logic [FULL_W-1:0] a_q, b_q;
    logic [FULL_W-1:0] z0_q, z2_q, zd_q;
    logic              neg_q;
    logic [PROD_W-1:0] p_q, p_d;
    logic [CNT_W-1:0]  cnt_q;

    logic [HALF_W-1:0] xl, xh, yl, yh;
    logic [HALF_W-1:0] mul_x, mul_y;
    logic [FULL_W-1:0] mul_z;
    logic [17:0]       zd_ext, mid;
    logic              accept, deliver;

    assign xl = a_q[HALF_W-1:0];
    assign xh = a_q[FULL_W-1:HALF_W];
    assign yl = b_q[HALF_W-1:0];
    assign yh = b_q[FULL_W-1:HALF_W];

    assign accept  = (state_q == IDLE) && bus.in_valid;
    assign deliver = (state_q == DONE) && bus.out_ready;

    karatsuba u_mul (
        .X (mul_x),
        .Y (mul_y),
        .Z (mul_z)
    );

    // Shared multiplier operand mux.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_q)
            M0:      begin mul_x = xl; mul_y = yl; end
            M2:      begin mul_x = xh; mul_y = yh; end
            M1:      begin mul_x = abs_diff(xl, xh); mul_y = abs_diff(yl, yh); end
            default: ;
        endcase
    end

    // mid = z0 + z2 - (xl-xh)(yl-yh); always non-negative, so modular
    // 18-bit arithmetic yields the exact value.
    always_comb begin
        zd_ext = {2'b0, zd_q};
        mid    = {2'b0, z0_q} + {2'b0, z2_q} + (neg_q ? zd_ext : (18'd0 - zd_ext));
        p_d    = {z2_q, 16'b0} + {6'b0, mid, 8'b0} + {16'b0, z0_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = M0;
            M0:      state_d = M2;
            M2:      state_d = M1;
            M1:      state_d = COMB;
            COMB:    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            z0_q  <= '0;
            z2_q  <= '0;
            zd_q  <= '0;
            neg_q <= 1'b0;
            p_q   <= '0;
            cnt_q <= '0;
        end else begin
            if (accept) begin
                a_q <= bus.a;
                b_q <= bus.b;
            end
            if (state_q == M0) z0_q <= mul_z;
            if (state_q == M2) z2_q <= mul_z;
            if (state_q == M1) begin
                zd_q  <= mul_z;
                neg_q <= (xl < xh) ^ (yl < yh);
            end
            if (state_q == COMB) p_q <= p_d;
            if (deliver && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.p         = p_q;
    assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_karatsuba_seq16.sv
module tb_karatsuba_seq16;

    logic clk;
    logic rst_n;

    karatsuba_seq16_if #(.CNT_W(16)) bus  ();
    karatsuba_seq16_if #(.CNT_W(2))  bus2 ();

    karatsuba_seq16 #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    karatsuba_seq16 #(.CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_cnt;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    // One full transaction on the main DUT; out_ready low until DONE.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic [31:0] te);
        int  k;
        bit  ok;
        bus.a        = ta;
        bus.b        = tb_;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.a = 16'hDEAD;
        bus.b = 16'hBEEF;
        chk("accept", 64'(ok), 64'd1);
        k = 1;
        while (!bus.out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("latency", 64'(k), 64'd5);
        chk("product", 64'(bus.p), 64'(te));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        exp_cnt++;
        chk("out_valid_after_hs", 64'(bus.out_valid), 64'd0);
        chk("op_count", 64'(bus.op_count), 64'(exp_cnt));
    endtask

    task automatic run_small(input logic [15:0] ta, input logic [15:0] tb_, input logic [31:0] te);
        bit ok;
        bus2.a = ta;
        bus2.b = tb_;
        bus2.in_valid = 1'b1;
        bus2.out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = bus2.in_ready;
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0;
        for (int i = 0; i < 20 && !bus2.out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("small_product", 64'(bus2.p), 64'(te));
        @(posedge clk); #1;
    endtask

    initial begin
        int          acc_cyc[2];
        int          n_acc, got;
        logic [31:0] got_p[2];
        bit          acc_now, ov_now, overlap;
        logic [31:0] p_now, p_hold;

        vecs[0] = '{16'h0011, 16'h0011, 32'h00000121};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h1234, 16'h5678, 32'h06260060};
        vecs[3] = '{16'h01FF, 16'hFF01, 32'h01FD02FF};
        vecs[4] = '{16'h8000, 16'h0002, 32'h00010000};
        vecs[5] = '{16'h00FF, 16'hFF00, 32'h00FE0100};

        bus.in_valid = 0; bus.out_ready = 0; bus.a = 0; bus.b = 0;
        bus2.in_valid = 0; bus2.out_ready = 0; bus2.a = 0; bus2.b = 0;
        exp_cnt = 0;
        rst_n = 1'b0;
        #23;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_p", 64'(bus.p), 64'd0);
        chk("rst_op_count", 64'(bus.op_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Table-driven products
        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].p);

        // Back-to-back with in_valid and out_ready held high
        bus.a = 16'h1234; bus.b = 16'h5678;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        n_acc = 0; got = 0; overlap = 0;
        for (int c = 0; c < 40 && got < 2; c++) begin
            acc_now = bus.in_ready && bus.in_valid;
            ov_now  = bus.out_valid;
            p_now   = bus.p;
            if (bus.in_ready && bus.out_valid) overlap = 1'b1;
            @(posedge clk); #1;
            if (acc_now && n_acc < 2) begin
                acc_cyc[n_acc] = c;
                n_acc++;
                if (n_acc == 1) begin
                    bus.a = 16'h01FF; bus.b = 16'hFF01;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (ov_now) begin
                got_p[got] = p_now;
                got++;
            end
        end
        bus.out_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd2;
        chk("b2b_count", 64'(got), 64'd2);
        chk("b2b_accepts", 64'(n_acc), 64'd2);
        chk("b2b_p0", 64'(got_p[0]), 64'h06260060);
        chk("b2b_p1", 64'(got_p[1]), 64'h01FD02FF);
        chk("b2b_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
        chk("b2b_ready_in_done", 64'(overlap), 64'd0);
        chk("b2b_op_count", 64'(bus.op_count), 64'(exp_cnt));

        // Backpressure: hold DONE for 3 cycles with a competing in_valid
        bus.a = 16'h0000; bus.b = 16'hABCD; bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !bus.in_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.a = 16'h1111; bus.b = 16'h2222;
        for (int i = 0; i < 20 && !bus.out_valid; i++) begin
            @(posedge clk); #1;
        end
        p_hold = bus.p;
        chk("bp_p_zero", 64'(p_hold), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_p_stable", 64'(bus.p), 64'(p_hold));
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        exp_cnt++;
        chk("bp_hs_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_no_accept_in_done", 64'(bus.in_ready), 64'd1);
        chk("bp_op_count", 64'(bus.op_count), 64'(exp_cnt));

        // Reset asserted during M2 aborts the operation
        bus.a = 16'h1234; bus.b = 16'h5678; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_p", 64'(bus.p), 64'd0);
        chk("abort_op_count", 64'(bus.op_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_emit", 64'(bus.out_valid), 64'd0);
        end
        chk("abort_cnt_hold", 64'(bus.op_count), 64'd0);
        run_op(16'h00FF, 16'h0100, 32'h0000FF00);

        // Narrow counter saturates at all-ones
        run_small(16'h0003, 16'h0005, 32'd15);
        run_small(16'h0100, 16'h0100, 32'h00010000);
        run_small(16'h00FF, 16'h00FF, 32'h0000FE01);
        chk("sat_at_3", 64'(bus2.op_count), 64'd3);
        run_small(16'hFFFF, 16'h0001, 32'h0000FFFF);
        run_small(16'h0002, 16'h8000, 32'h00010000);
        chk("sat_after_5", 64'(bus2.op_count), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
